// File: rtl/ppu_oam_pkg.sv
// Shared types and constants for the PPU sprite-RAM (OAM) arbiter.
// No logic; no latency; no backpressure.
// Imported by the arbiter top and its DMA engine.
package ppu_oam_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_ALIGN = 2'd1,
        DMA_READ  = 2'd2,
        DMA_WRITE = 2'd3
    } dma_state_t;

    localparam int OAM_SIZE = 256;

    localparam logic [15:0] REG_OAMADDR = 16'h2003;
    localparam logic [15:0] REG_OAMDATA = 16'h2004;
    localparam logic [15:0] REG_OAMDMA  = 16'h4014;

endpackage

// File: rtl/ppu_oam_dma_engine.sv
// OAM DMA sequencer: copies DMA_BYTES bytes from CPU page into OAM via a write request.
// Latency: 1 + ALIGN_CYCLES + 2*DMA_BYTES cycles from dma_start to dma_busy falling.
// Backpressure: rendering holds the WRITE state (byte kept) until the arbiter can take it.
module ppu_oam_dma_engine
    import ppu_oam_pkg::*;
#(
    parameter int DMA_BYTES    = OAM_SIZE,
    parameter int ALIGN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    input  logic        rendering,
    output logic        dma_bus_rd,
    output logic [15:0] dma_bus_addr,
    input  logic [7:0]  dma_bus_data,
    output logic        dma_busy,
    output logic        wr_req,
    output logic [7:0]  wr_data,
    output logic        wr_done
);

    localparam logic [8:0] LAST_BYTE  = 9'(DMA_BYTES - 1);
    localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_CYCLES - 1);

    dma_state_t state, next_state;
    logic [7:0] page_q;
    logic [8:0] count_q;
    logic [7:0] align_q;
    logic [7:0] byte_q;
    logic       first_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DMA_IDLE;
            page_q  <= '0;
            count_q <= '0;
            align_q <= '0;
            byte_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state   <= next_state;
            first_q <= (state == DMA_READ);
            if (state == DMA_IDLE && dma_start) begin
                page_q  <= dma_page;
                count_q <= '0;
                align_q <= '0;
            end
            if (state == DMA_ALIGN)
                align_q <= align_q + 8'd1;
            if (first_q)
                byte_q <= dma_bus_data;
            if (wr_done)
                count_q <= count_q + 9'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DMA_IDLE:  if (dma_start) next_state = DMA_ALIGN;
            DMA_ALIGN: if (align_q == ALIGN_LAST) next_state = DMA_READ;
            DMA_READ:  next_state = DMA_WRITE;
            DMA_WRITE: if (wr_done) next_state = (count_q == LAST_BYTE) ? DMA_IDLE : DMA_READ;
            default:   next_state = DMA_IDLE;
        endcase
    end

    // Bus data is only valid in the first WRITE cycle; later cycles use the captured copy.
    assign wr_data      = first_q ? dma_bus_data : byte_q;
    assign wr_req       = (state == DMA_WRITE);
    assign wr_done      = wr_req && !rendering;
    assign dma_bus_rd   = (state == DMA_READ);
    assign dma_bus_addr = {page_q, count_q[7:0]};
    assign dma_busy     = (state != DMA_IDLE);

endmodule

// File: rtl/ppu_oam_arbiter.sv
// Single-port OAM arbiter: evaluator > DMA write > CPU OAMDATA write > CPU read.
// Latency: eval_data 1 cycle after eval_addr; cpu_rdata registered one cycle after the RAM read.
// Backpressure: CPU stalled for the whole DMA; CPU writes during rendering/DMA are dropped.
module ppu_oam_arbiter
    import ppu_oam_pkg::*;
#(
    parameter int DMA_BYTES    = OAM_SIZE,
    parameter int ALIGN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rendering,
    input  logic [7:0]  eval_addr,
    output logic [7:0]  eval_data,
    input  logic        cpu_oamaddr_wr,
    input  logic        cpu_oamdata_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [7:0]  oam_addr,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic        dma_bus_rd,
    output logic [15:0] dma_bus_addr,
    input  logic [7:0]  dma_bus_data,
    output logic        dma_busy,
    output logic        cpu_stall,
    output logic [7:0]  ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    logic       dma_wr_req;
    logic [7:0] dma_wr_data;
    logic       dma_wr_done;
    logic       cpu_wr_ok;
    logic       rd_now;
    logic       rd_q;
    logic [7:0] oam_addr_q;

    ppu_oam_dma_engine #(
        .DMA_BYTES    (DMA_BYTES),
        .ALIGN_CYCLES (ALIGN_CYCLES)
    ) u_dma (
        .clk          (clk),
        .rst          (rst),
        .dma_start    (dma_start),
        .dma_page     (dma_page),
        .rendering    (rendering),
        .dma_bus_rd   (dma_bus_rd),
        .dma_bus_addr (dma_bus_addr),
        .dma_bus_data (dma_bus_data),
        .dma_busy     (dma_busy),
        .wr_req       (dma_wr_req),
        .wr_data      (dma_wr_data),
        .wr_done      (dma_wr_done)
    );

    // An OAMADDR load in the same cycle wins over the data write.
    assign cpu_wr_ok = cpu_oamdata_wr && !cpu_oamaddr_wr && !rendering && !dma_busy;

    always_comb begin
        ram_addr  = oam_addr_q;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        rd_now    = 1'b0;
        if (rendering) begin
            ram_addr = eval_addr;
        end else if (dma_wr_req) begin
            ram_we    = 1'b1;
            ram_wdata = dma_wr_data;
        end else if (cpu_wr_ok) begin
            ram_we    = 1'b1;
            ram_wdata = cpu_wdata;
        end else begin
            rd_now = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oam_addr_q <= 8'h00;
            rd_q       <= 1'b0;
            cpu_rdata  <= 8'h00;
        end else begin
            rd_q <= rd_now;
            if (rd_q)
                cpu_rdata <= ram_rdata;
            if (dma_wr_done || cpu_wr_ok)
                oam_addr_q <= oam_addr_q + 8'd1;
            else if (cpu_oamaddr_wr && !dma_busy)
                oam_addr_q <= cpu_wdata;
        end
    end

    assign oam_addr  = oam_addr_q;
    assign eval_data = ram_rdata;
    assign cpu_stall = dma_busy;

endmodule

// File: tb/tb_ppu_oam_arbiter.sv
// Directed bench for ppu_oam_arbiter with a behavioural OAM RAM and CPU bus model.
module tb_ppu_oam_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rendering = 1'b0;
    logic [7:0]  eval_addr = 8'h00;
    logic [7:0]  eval_data;
    logic        cpu_oamaddr_wr = 1'b0;
    logic        cpu_oamdata_wr = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic [7:0]  oam_addr;
    logic        dma_start = 1'b0;
    logic [7:0]  dma_page = 8'h00;
    logic        dma_bus_rd;
    logic [15:0] dma_bus_addr;
    logic [7:0]  dma_bus_data = 8'h00;
    logic        dma_busy;
    logic        cpu_stall;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;

    logic [7:0]  mem [256];
    logic [7:0]  exp_page = 8'h00;
    logic [7:0]  bus_xor = 8'h00;
    logic [7:0]  rd_idx = 8'h00;
    int          rd_cnt = 0;
    int          rd_err = 0;
    int          we_in_render = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ppu_oam_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rendering      (rendering),
        .eval_addr      (eval_addr),
        .eval_data      (eval_data),
        .cpu_oamaddr_wr (cpu_oamaddr_wr),
        .cpu_oamdata_wr (cpu_oamdata_wr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .oam_addr       (oam_addr),
        .dma_start      (dma_start),
        .dma_page       (dma_page),
        .dma_bus_rd     (dma_bus_rd),
        .dma_bus_addr   (dma_bus_addr),
        .dma_bus_data   (dma_bus_data),
        .dma_busy       (dma_busy),
        .cpu_stall      (cpu_stall),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    // Synchronous single-port OAM, read-before-write.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // CPU bus: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (dma_bus_rd) begin
            if (dma_bus_addr != {exp_page, rd_idx}) rd_err++;
            rd_idx++;
            rd_cnt++;
            dma_bus_data <= dma_bus_addr[7:0] ^ bus_xor;
        end
        if (rendering && ram_we) we_in_render++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_addr(input logic [7:0] v);
        cpu_oamaddr_wr = 1'b1;
        cpu_wdata      = v;
        tick();
        cpu_oamaddr_wr = 1'b0;
    endtask

    task automatic cpu_data(input logic [7:0] v);
        cpu_oamdata_wr = 1'b1;
        cpu_wdata      = v;
        tick();
        cpu_oamdata_wr = 1'b0;
    endtask

    // Runs one DMA; optionally raises rendering for 10 cycles at the WRITE of byte render_at,
    // and pokes a second dma_start at cycle poke_at.
    task automatic run_dma(input logic [7:0] page, input logic [7:0] xr, input int render_at,
                           input int poke_at, output int cycles);
        int left;
        bit armed;
        bit used;
        exp_page  = page;
        bus_xor   = xr;
        rd_cnt    = 0;
        rd_err    = 0;
        rd_idx    = 8'h00;
        dma_page  = page;
        dma_start = 1'b1;
        cycles    = 0;
        left      = 0;
        armed     = 1'b0;
        used      = 1'b0;
        do begin
            tick();
            cycles++;
            dma_start = (cycles == poke_at);
            if (cycles == poke_at) dma_page = 8'h07;
            if (left > 0) begin
                left--;
                if (left == 0) rendering = 1'b0;
            end else if (armed) begin
                rendering = 1'b1;
                left      = 10;
                armed     = 1'b0;
                used      = 1'b1;
            end
            if (!used && render_at >= 0 && dma_bus_rd && dma_bus_addr[7:0] == render_at[7:0])
                armed = 1'b1;
        end while (dma_busy && cycles < 3000);
        dma_start = 1'b0;
    endtask

    initial begin
        int cyc;
        int errs;
        int n;

        // Reset state
        #12;
        check_eq("rst_busy", dma_busy, 0);
        check_eq("rst_stall", cpu_stall, 0);
        check_eq("rst_bus_rd", dma_bus_rd, 0);
        check_eq("rst_bus_addr", dma_bus_addr, 0);
        check_eq("rst_ram_we", ram_we, 0);
        check_eq("rst_ram_wdata", ram_wdata, 0);
        check_eq("rst_cpu_rdata", cpu_rdata, 0);
        check_eq("rst_oam_addr", oam_addr, 0);
        tick();
        rst = 1'b1;
        tick();

        // 1: full DMA from page 0x02, OAMADDR 0
        run_dma(8'h02, 8'hA5, -1, -1, cyc);
        check_eq("t1_cycles", cyc, 514);
        check_eq("t1_reads", rd_cnt, 256);
        check_eq("t1_read_addr_err", rd_err, 0);
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== (8'(i) ^ 8'hA5)) errs++;
        check_eq("t1_oam_content_err", errs, 0);
        check_eq("t1_oam37", mem[8'h37], 8'h92);
        check_eq("t1_oam_addr", oam_addr, 8'h00);

        // 2: OAMADDR 0xFC wraps; a dma_start while busy is ignored
        cpu_addr(8'hFC);
        run_dma(8'h03, 8'h3C, -1, 100, cyc);
        check_eq("t2_cycles", cyc, 514);
        check_eq("t2_reads", rd_cnt, 256);
        check_eq("t2_read_addr_err", rd_err, 0);
        check_eq("t2_oam_fc", mem[8'hFC], 8'h3C);
        check_eq("t2_oam_00", mem[8'h00], 8'h38);
        check_eq("t2_oam_addr", oam_addr, 8'hFC);

        // 3: rendering for 10 cycles during WRITE of byte 40
        cpu_addr(8'h00);
        we_in_render = 0;
        run_dma(8'h04, 8'h5A, 40, -1, cyc);
        check_eq("t3_cycles", cyc, 524);
        check_eq("t3_we_in_render", we_in_render, 0);
        check_eq("t3_oam28", mem[8'h28], 8'h72);
        check_eq("t3_oam29", mem[8'h29], 8'h73);
        check_eq("t3_oam_addr", oam_addr, 8'h00);

        // 4: CPU register writes and read-back
        cpu_addr(8'h10);
        cpu_data(8'h55);
        tick();
        check_eq("t4_oam10", mem[8'h10], 8'h55);
        check_eq("t4_oam_addr", oam_addr, 8'h11);
        cpu_addr(8'h10);
        tick();
        tick();
        check_eq("t4_cpu_rdata", cpu_rdata, 8'h55);
        cpu_oamaddr_wr = 1'b1;
        cpu_oamdata_wr = 1'b1;
        cpu_wdata      = 8'h20;
        tick();
        cpu_oamaddr_wr = 1'b0;
        cpu_oamdata_wr = 1'b0;
        tick();
        check_eq("t4_collide_addr", oam_addr, 8'h20);
        check_eq("t4_collide_mem", mem[8'h20], 8'h7A);

        // 5: evaluator reads; concurrent OAMDATA write is dropped
        rendering = 1'b1;
        eval_addr = 8'h00;
        tick();
        check_eq("t5_eval0", eval_data, 8'h5A);
        eval_addr      = 8'h01;
        cpu_oamdata_wr = 1'b1;
        cpu_wdata      = 8'h99;
        tick();
        cpu_oamdata_wr = 1'b0;
        check_eq("t5_eval1", eval_data, 8'h5B);
        eval_addr = 8'h02;
        tick();
        check_eq("t5_eval2", eval_data, 8'h58);
        rendering = 1'b0;
        tick();
        check_eq("t5_oam_addr", oam_addr, 8'h20);
        check_eq("t5_oam20", mem[8'h20], 8'h7A);

        // 6: reset in the middle of a DMA, then a clean DMA
        cpu_addr(8'h30);
        exp_page  = 8'h06;
        dma_page  = 8'h06;
        dma_start = 1'b1;
        tick();
        dma_start = 1'b0;
        cpu_addr(8'h77);
        check_eq("t6_addr_wr_busy", oam_addr, 8'h30);
        n = 0;
        while (!(dma_bus_rd && dma_bus_addr[7:0] == 8'd100) && n < 1000) begin
            tick();
            n++;
        end
        check_eq("t6_reached_100", (n < 1000), 1);
        rst = 1'b0;
        #1;
        check_eq("t6_busy", dma_busy, 0);
        check_eq("t6_stall", cpu_stall, 0);
        check_eq("t6_oam_addr", oam_addr, 8'h00);
        check_eq("t6_bus_rd", dma_bus_rd, 0);
        tick();
        rst = 1'b1;
        tick();
        run_dma(8'h05, 8'hC3, -1, -1, cyc);
        check_eq("t6_cycles", cyc, 514);
        check_eq("t6_reads", rd_cnt, 256);
        check_eq("t6_read_addr_err", rd_err, 0);
        check_eq("t6_oam_addr_end", oam_addr, 8'h00);
        check_eq("t6_oam64", mem[8'h64], 8'hA7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
